serv_mdu: RTL and testbench
===========================

SERV_MDU -- requirements
Module: serv_mdu

Interface
REQ-001 Parameter: FAST_ZERO, default 1, 1 = division by zero completes without iterating.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_mdu_valid  in  1  request strobe, level; sampled only in IDLE.
REQ-005 i_mdu_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 i_mdu_rs1  in  32  operand A, full word from the core's buffer register.
REQ-007 i_mdu_rs2  in  32  operand B, full word from the core's data-out register.
REQ-008 o_mdu_rd  out  32  result word; valid while o_mdu_ready=1, held until the next result load.
REQ-009 o_mdu_ready  out  1  one-cycle completion pulse.

Function
REQ-010 FSM states: IDLE, CALC, DONE; no other states are reachable.
REQ-011 IDLE & i_mdu_valid at edge E0 -> latch op, magnitudes of operands (signed per op), result sign -> CALC; 5-bit iteration counter cleared.
REQ-012 Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 signed, rs2 unsigned; MULHU/DIVU/REMU treat both as unsigned.
REQ-013 CALC: one radix-2 iteration per edge, E1..E32; counter increments per edge; wraps 31->0 on E32 -> DONE.
REQ-014 Multiply: unsigned shift-add into a 64-bit accumulator; two's-complement negate the 64-bit product if the result sign is negative.
REQ-015 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-016 Divide: restoring, unsigned magnitudes; quotient negated if operand signs differ; remainder takes the sign of rs1.
REQ-017 Division by zero: quotient = 0xFFFFFFFF, remainder = rs1 unmodified, for signed and unsigned ops.
REQ-018 Overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same operands = 0x00000000.
REQ-019 At E33 o_mdu_rd is loaded with the final result and o_mdu_ready rises (DONE); at E34 o_mdu_ready falls and the FSM returns to IDLE.
REQ-020 Latency: o_mdu_ready is high exactly in the cycle between E33 and E34; 34 edges from acceptance to IDLE.
REQ-021 FAST_ZERO=1 & divide op & rs2==0: IDLE -> DONE at E0 with the REQ-017 result; o_mdu_ready is high between E1 and E2.
REQ-022 FAST_ZERO=0: division by zero iterates the full 32 cycles and produces the REQ-017 values.
REQ-023 i_mdu_valid is ignored in CALC and DONE; a valid still high in the DONE cycle does not start a new operation.
REQ-024 Operand inputs are not sampled after E0; changes during CALC do not affect the result.
REQ-025 A new request is accepted in the first IDLE cycle after DONE (earliest edge E34+1).
REQ-026 o_mdu_ready is never high for 2 consecutive cycles.

Reset
REQ-027 i_rst_n=0 forces asynchronously: state=IDLE, counter=0, o_mdu_ready=0, o_mdu_rd=0x00000000, all datapath registers=0.
REQ-028 Reset asserted mid-CALC aborts the operation; no o_mdu_ready pulse follows for the aborted request.
REQ-029 First request is accepted on the first rising edge after reset release with i_mdu_valid=1.

Verification
REQ-030 MUL rs1=0x00000007, rs2=0xFFFFFFFD -> o_mdu_rd=0xFFFFFFEB, ready 33 edges after acceptance.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-032 DIV 0xFFFFFFF9/0x00000002 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; with FAST_ZERO=1 ready is high between E1 and E2.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
REQ-035 Assert i_rst_n=0 at E10 of a MUL -> outputs=0 immediately; no ready pulse; a following MULHU 2*3 -> 0x00000000 with normal latency.

Source files
------------

// File: rtl/serv_mdu.sv
// Bit-serial RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, 32 iterations per operation, shared 64-bit accumulator.
module serv_mdu #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mdu_valid,
    input  logic [2:0]  i_mdu_op,
    input  logic [31:0] i_mdu_rs1,
    input  logic [31:0] i_mdu_rs2,
    output logic [31:0] o_mdu_rd,
    output logic        o_mdu_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;

    state_t      r_state;
    state_t      w_next_state;

    logic [2:0]  r_op;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic        r_neg_q;
    logic        r_neg_a;
    logic        r_div_zero;
    logic [4:0]  r_cnt;
    logic [31:0] r_rd;
    logic        r_ready;

    // Request decode (only meaningful in IDLE)
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_is_div;
    logic        w_b_zero;
    logic        w_fast_zero;

    assign w_is_div    = i_mdu_op[2];
    assign w_a_signed  = i_mdu_op[2] ? ~i_mdu_op[0] : (i_mdu_op[1:0] != 2'b11);
    assign w_b_signed  = i_mdu_op[2] ? ~i_mdu_op[0] : ~i_mdu_op[1];
    assign w_a_neg     = w_a_signed & i_mdu_rs1[31];
    assign w_b_neg     = w_b_signed & i_mdu_rs2[31];
    assign w_a_mag     = w_a_neg ? (32'd0 - i_mdu_rs1) : i_mdu_rs1;
    assign w_b_mag     = w_b_neg ? (32'd0 - i_mdu_rs2) : i_mdu_rs2;
    assign w_b_zero    = (i_mdu_rs2 == 32'd0);
    assign w_fast_zero = FAST_ZERO & w_is_div & w_b_zero;

    // Multiply step: conditionally add multiplicand to the upper half, shift right with carry
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide step: partial remainder in the upper half, quotient bits shift in at the bottom
    logic [32:0] w_div_shift;
    logic [31:0] w_div_diff;
    logic        w_div_ok;
    logic [63:0] w_div_next;

    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_diff  = w_div_shift[31:0] - r_b;
    assign w_div_next  = {(w_div_ok ? w_div_diff : w_div_shift[31:0]), r_acc[30:0], w_div_ok};

    // Sign fix-up of the finished accumulator
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_result;

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_div_zero ? 32'hFFFF_FFFF
                               : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_rem  = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_result = w_rem;
        case (r_op)
            OP_MUL:           w_result = w_prod[31:0];
            3'b001, 3'b010,
            3'b011:           w_result = w_prod[63:32];
            OP_DIV, OP_DIVU:  w_result = w_quot;
            default:          w_result = w_rem;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_mdu_valid) begin
                    w_next_state = w_fast_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                // DONE spans two cycles: one to load the result, one with ready high
                if (r_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op       <= 3'd0;
            r_acc      <= 64'd0;
            r_b        <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_a    <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= 5'd0;
            r_rd       <= 32'd0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (i_mdu_valid) begin
                        r_op       <= i_mdu_op;
                        r_b        <= w_b_mag;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_a    <= w_a_neg;
                        r_div_zero <= w_is_div & w_b_zero;
                        r_cnt      <= 5'd0;
                        // Fast zero skips iteration, so preload the state 32 divide steps would reach
                        r_acc      <= w_fast_zero ? {w_a_mag, 32'hFFFF_FFFF}
                                                  : {32'd0, w_a_mag};
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                end
                S_DONE: begin
                    if (!r_ready) begin
                        r_rd    <= w_result;
                        r_ready <= 1'b1;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign o_mdu_rd    = r_rd;
    assign o_mdu_ready = r_ready;

endmodule

// File: tb/tb_serv_mdu.sv
// Bench for serv_mdu: directed vectors, randomized ops against an arithmetic reference,
// plus reset-abort and back-to-back request sequences on both FAST_ZERO variants.
module tb_serv_mdu;

    logic        clk;
    logic        rst_n;
    logic        mdu_valid;
    logic [2:0]  mdu_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd_f;
    logic        ready_f;
    logic [31:0] rd_s;
    logic        ready_s;

    int n_checks = 0;
    int n_errors = 0;

    serv_mdu #(.FAST_ZERO(1'b1)) dut_fast (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mdu_valid (mdu_valid),
        .i_mdu_op    (mdu_op),
        .i_mdu_rs1   (rs1),
        .i_mdu_rs2   (rs2),
        .o_mdu_rd    (rd_f),
        .o_mdu_ready (ready_f)
    );

    serv_mdu #(.FAST_ZERO(1'b0)) dut_slow (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mdu_valid (mdu_valid),
        .i_mdu_op    (mdu_op),
        .i_mdu_rs1   (rs1),
        .i_mdu_rs2   (rs2),
        .o_mdu_rd    (rd_s),
        .o_mdu_ready (ready_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics computed with wide signed/unsigned arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub;
        logic [63:0] p;
        int q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one request (caller is away from the clock edge), then watch 40 edges
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat_f, lat_s, np_f, np_s, exp_lat_f;
        logic [31:0] got_f, got_s;
        lat_f = 0; lat_s = 0; np_f = 0; np_s = 0;
        got_f = 32'd0; got_s = 32'd0;
        exp_lat_f = (op[2] && b == 32'd0) ? 1 : 33;
        mdu_valid = 1'b1;
        mdu_op    = op;
        rs1       = a;
        rs2       = b;
        @(posedge clk); #1;
        mdu_valid = 1'b0;
        mdu_op    = 3'($urandom);
        rs1       = $urandom;
        rs2       = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready_f) begin
                np_f++;
                if (lat_f == 0) begin lat_f = k; got_f = rd_f; end
            end
            if (ready_s) begin
                np_s++;
                if (lat_s == 0) begin lat_s = k; got_s = rd_s; end
            end
        end
        check($sformatf("%s rd_fast", tag), got_f, exp);
        check($sformatf("%s rd_slow", tag), got_s, exp);
        check($sformatf("%s lat_fast", tag), lat_f, exp_lat_f);
        check($sformatf("%s lat_slow", tag), lat_s, 33);
        check($sformatf("%s pulses_fast", tag), np_f, 1);
        check($sformatf("%s pulses_slow", tag), np_s, 1);
    endtask

    vec_t vecs[14];

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        int edges_f[$];
        int edges_s[$];
        int np_f, np_s;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};

        rst_n     = 1'b0;
        mdu_valid = 1'b0;
        mdu_op    = 3'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rd_fast", rd_f, 32'd0);
        check("reset ready_fast", ready_f, 1'b0);
        check("reset rd_slow", rd_s, 32'd0);
        check("reset ready_slow", ready_s, 1'b0);

        // First request lands on the very first edge after release
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 120; i++) begin
            r_op = 3'($urandom_range(7));
            case ($urandom_range(5))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(15));
                default: r_b = $urandom;
            endcase
            r_a = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a multiply aborts it without a pulse
        run_op(3'd0, 32'd3, 32'd5, 32'd15, "pre_abort");
        mdu_valid = 1'b1; mdu_op = 3'd0; rs1 = 32'h1234_5678; rs2 = 32'h9;
        @(posedge clk); #1;
        mdu_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort rd_fast", rd_f, 32'd0);
        check("abort ready_fast", ready_f, 1'b0);
        check("abort rd_slow", rd_s, 32'd0);
        np_f = 0; np_s = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready_f) np_f++;
            if (ready_s) np_s++;
        end
        check("abort no_pulse_fast", np_f, 0);
        check("abort no_pulse_slow", np_s, 0);
        run_op(3'd3, 32'd2, 32'd3, 32'd0, "post_abort");

        // Valid held high: DONE ignores it, the next acceptance is the first IDLE edge
        mdu_valid = 1'b1; mdu_op = 3'd3; rs1 = 32'hFFFF_FFFF; rs2 = 32'h0000_0010;
        @(posedge clk); #1;
        for (int k = 1; k <= 69; k++) begin
            @(posedge clk); #1;
            if (ready_f) edges_f.push_back(k);
            if (ready_s) edges_s.push_back(k);
        end
        mdu_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("b2b count_fast", edges_f.size(), 2);
        check("b2b count_slow", edges_s.size(), 2);
        if (edges_f.size() == 2) begin
            check("b2b first_fast", edges_f[0], 33);
            check("b2b second_fast", edges_f[1], 68);
        end
        if (edges_s.size() == 2) begin
            check("b2b second_slow", edges_s[1], 68);
        end
        check("b2b rd_fast", rd_f, 32'h0000_000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
